// File: rtl/v20_bus_pkg.sv
// Shared types and constants for the V20/8088 minimum-mode bus master.
package v20_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    TW,
    T4,
    TI
  } bus_state_e;

  localparam int TSTATE_CLKS = 2;
  localparam logic [7:0] AD_RD_ERR = 8'hFF;

endpackage

// File: rtl/bus_clk_div.sv
// Divides clk into T-states; phase is high in the second half of each T-state.
module bus_clk_div
  import v20_bus_pkg::*;
(
  input  logic clk,
  input  logic srst,
  output logic phase,
  output logic phase_next,
  output logic bus_clk
);

  localparam int CNT_W = (TSTATE_CLKS > 2) ? $clog2(TSTATE_CLKS) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_W'(TSTATE_CLKS - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase      = cnt_q[CNT_W-1];
  assign phase_next = cnt_d[CNT_W-1];
  assign bus_clk    = cnt_q[CNT_W-1];

endmodule

// File: rtl/v20_bus_master.sv
// Single-transaction initiator for the multiplexed 8-bit V20/8088 minimum-mode bus.
// Every output is a flop loaded from the next-state view so pins line up with the state.
module v20_bus_master
  import v20_bus_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [19:0] iReqAddr,
  input  logic [7:0]  iReqData,
  input  logic        iReqWr,
  input  logic        iReqIo,
  output logic        oRspValid,
  output logic [7:0]  oRspData,
  output logic        oRspErr,
  output logic        oBusClk,
  output logic        oBusAle,
  output logic        oBusIom,
  output logic        oBusDtr,
  output logic        oBusSso,
  output logic [11:0] oBusAddr,
  output logic [7:0]  oBusAd,
  output logic        oBusAdDir,
  input  logic [7:0]  iBusAd,
  input  logic        iBusReady
);

  localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic phase;
  logic phase_nx;

  bus_clk_div u_clk_div (
    .clk        (iClk),
    .srst       (iReset),
    .phase      (phase),
    .phase_next (phase_nx),
    .bus_clk    (oBusClk)
  );

  bus_state_e        state_q, state_d;
  logic              pend_q, pend_d;
  logic [19:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_q, wr_d;
  logic              io_q, io_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ale_q, ale_d;
  logic              iom_q, iom_d;
  logic              dtr_q, dtr_d;
  logic              sso_q, sso_d;
  logic [11:0]       baddr_q, baddr_d;
  logic [7:0]        ad_q, ad_d;
  logic              addir_q, addir_d;

  logic hs;
  logic in_cycle;

  // Next-state: T-state changes only where phase is 1 (the 1->0 boundary).
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    io_d    = io_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    hs      = iReqValid && ready_q;

    if (hs) begin
      addr_d = iReqAddr;
      data_d = iReqData;
      wr_d   = iReqWr;
      io_d   = iReqIo;
    end

    case (state_q)
      IDLE: begin
        if (phase) begin
          if (pend_q || hs) begin
            state_d = T1;
            pend_d  = 1'b0;
          end
        end else if (hs) begin
          pend_d = 1'b1;
        end
      end
      T1: begin
        wcnt_d = '0;
        err_d  = 1'b0;
        if (phase) state_d = T2;
      end
      T2: begin
        if (phase) state_d = T3;
      end
      T3, TW: begin
        if (phase) begin
          if (iBusReady) begin
            state_d = T4;
            rdata_d = iBusAd;
          end else if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
            state_d = T4;
            err_d   = 1'b1;
            rdata_d = AD_RD_ERR;
          end else begin
            state_d = TW;
            wcnt_d  = wcnt_q + 1'b1;
          end
        end
      end
      T4: begin
        if (phase) state_d = TI;
      end
      TI: begin
        // A request taken in the last half of TI skips IDLE, giving a 10-clock cadence.
        if (phase) state_d = hs ? T1 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the cycle that state_d/phase_nx describe.
  always_comb begin
    in_cycle    = (state_d == T1) || (state_d == T2) || (state_d == T3) ||
                  (state_d == TW) || (state_d == T4);
    ready_d     = ((state_d == IDLE) && !pend_d) || ((state_d == TI) && phase_nx);
    ale_d       = (state_d == T1);
    baddr_d     = in_cycle ? addr_d[19:8] : 12'h000;
    iom_d       = in_cycle && io_d;
    dtr_d       = in_cycle && wr_d;
    sso_d       = !(in_cycle && (state_d != T4));
    addir_d     = (state_d == T1) || (in_cycle && wr_d);
    ad_d        = 8'h00;
    if (state_d == T1) begin
      ad_d = addr_d[7:0];
    end else if (in_cycle && wr_d) begin
      ad_d = data_d;
    end
    rsp_valid_d = (state_d == T4) && phase_nx;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_valid_d) begin
      rsp_data_d = wr_d ? data_d : rdata_d;
      rsp_err_d  = err_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      addr_q      <= 20'h00000;
      data_q      <= 8'h00;
      wr_q        <= 1'b0;
      io_q        <= 1'b0;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      ale_q       <= 1'b0;
      iom_q       <= 1'b0;
      dtr_q       <= 1'b0;
      sso_q       <= 1'b1;
      baddr_q     <= 12'h000;
      ad_q        <= 8'h00;
      addir_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      io_q        <= io_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wcnt_q      <= wcnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      ale_q       <= ale_d;
      iom_q       <= iom_d;
      dtr_q       <= dtr_d;
      sso_q       <= sso_d;
      baddr_q     <= baddr_d;
      ad_q        <= ad_d;
      addir_q     <= addir_d;
    end
  end

  assign oReqReady = ready_q;
  assign oRspValid = rsp_valid_q;
  assign oRspData  = rsp_data_q;
  assign oRspErr   = rsp_err_q;
  assign oBusAle   = ale_q;
  assign oBusIom   = iom_q;
  assign oBusDtr   = dtr_q;
  assign oBusSso   = sso_q;
  assign oBusAddr  = baddr_q;
  assign oBusAd    = ad_q;
  assign oBusAdDir = addir_q;

endmodule
